// File: rtl/sound_pulse_gen.sv
// sound_pulse_gen: square channel with duty, length, envelope and sweep.
// Every timebase arrives as a one-cycle enable on clk.
module sound_pulse_gen #(
  parameter int FREQ_W    = 11,
  parameter int LEN_W     = 6,
  parameter int VOL_W     = 4,
  parameter int HAS_SWEEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freq_tick,
  input  logic              length_tick,
  input  logic              env_tick,
  input  logic              sweep_tick,
  input  logic              trigger,
  input  logic              freq_wr,
  input  logic [FREQ_W-1:0] frequency,
  input  logic [1:0]        wave_duty,
  input  logic              length_wr,
  input  logic [LEN_W-1:0]  length,
  input  logic              length_en,
  input  logic [VOL_W-1:0]  initial_volume,
  input  logic              env_increasing,
  input  logic [2:0]        env_period,
  input  logic [2:0]        sweep_period,
  input  logic              sweep_decreasing,
  input  logic [2:0]        sweep_shift,
  output logic [VOL_W-1:0]  level,
  output logic              enable
);

  localparam int LC_W = LEN_W + 1;
  localparam logic [FREQ_W-1:0] F_MAX = '1;
  localparam logic [VOL_W-1:0]  V_MAX = '1;
  localparam logic [LC_W-1:0]   L_FULL = {1'b1, {LEN_W{1'b0}}};

  logic              en_q, en_d;
  logic [VOL_W-1:0]  level_q, level_d;
  logic [FREQ_W-1:0] div_q, div_d;
  logic [2:0]        pos_q, pos_d;
  logic [LC_W-1:0]   len_q, len_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [2:0]        envt_q, envt_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [3:0]        swt_q, swt_d;
  logic              swact_q, swact_d;

  logic              dac_en;
  logic              duty_high;
  logic              trig_ovf;
  logic [FREQ_W:0]   sw_new;
  logic              sw_ovf2;
  logic [LC_W-1:0]   len_ld;
  logic [3:0]        swt_rld;

  function automatic logic [FREQ_W:0] sweep_calc(
    input logic [FREQ_W-1:0] f,
    input logic [2:0]        sh,
    input logic              dec
  );
    logic [FREQ_W:0] d;
    d = {1'b0, f >> sh};
    return dec ? ({1'b0, f} - d) : ({1'b0, f} + d);
  endfunction

  // Subtraction cannot exceed the input, so only addition can overflow.
  function automatic logic add_ovf(
    input logic [FREQ_W-1:0] f,
    input logic [2:0]        sh
  );
    logic [FREQ_W:0] s;
    s = {1'b0, f} + {1'b0, f >> sh};
    return s[FREQ_W];
  endfunction

  always_comb begin
    dac_en = (initial_volume != '0) | env_increasing;

    duty_high = 1'b0;
    unique case (1'b1)
      (wave_duty == 2'b00): duty_high = (pos_q == 3'd7);
      (wave_duty == 2'b01): duty_high = (pos_q >= 3'd6);
      (wave_duty == 2'b10): duty_high = pos_q[2];
      default:              duty_high = (pos_q <= 3'd5);
    endcase

    sw_new   = sweep_calc(shadow_q, sweep_shift, sweep_decreasing);
    sw_ovf2  = add_ovf(sw_new[FREQ_W-1:0], sweep_shift)
               & ~sweep_decreasing;
    trig_ovf = (HAS_SWEEP != 0) && (sweep_shift != 3'd0)
               && !sweep_decreasing
               && add_ovf(frequency, sweep_shift);
    len_ld   = length_wr ? (L_FULL - {1'b0, length}) : len_q;
    swt_rld  = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};

    en_d     = en_q;
    div_d    = div_q;
    pos_d    = pos_q;
    len_d    = len_q;
    vol_d    = vol_q;
    envt_d   = envt_q;
    shadow_d = shadow_q;
    swt_d    = swt_q;
    swact_d  = swact_q;
    level_d  = (en_q && duty_high) ? vol_q : '0;

    if (trigger) begin
      en_d     = dac_en & ~trig_ovf;
      div_d    = frequency;
      vol_d    = initial_volume;
      envt_d   = env_period;
      len_d    = (len_ld == '0) ? L_FULL : len_ld;
      shadow_d = frequency;
      swt_d    = swt_rld;
      swact_d  = (sweep_period != 3'd0) | (sweep_shift != 3'd0);
    end else begin
      if (freq_tick) begin
        if (div_q == F_MAX) begin
          div_d = shadow_q;
          pos_d = pos_q + 3'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      if (length_wr) begin
        len_d = len_ld;
      end else if (length_tick && length_en && len_q != '0) begin
        len_d = len_q - 1'b1;
        if (len_q == LC_W'(1)) en_d = 1'b0;
      end

      if (env_tick && env_period != 3'd0) begin
        if (envt_q <= 3'd1) begin
          envt_d = env_period;
          if (env_increasing) begin
            if (vol_q != V_MAX) vol_d = vol_q + 1'b1;
          end else begin
            if (vol_q != '0) vol_d = vol_q - 1'b1;
          end
        end else begin
          envt_d = envt_q - 3'd1;
        end
      end

      // Sweep math fires only when its timer expires.
      if (HAS_SWEEP != 0 && sweep_tick && swact_q) begin
        if (swt_q <= 4'd1) begin
          swt_d = swt_rld;
          if (sweep_period != 3'd0) begin
            if (sw_new[FREQ_W]) begin
              en_d = 1'b0;
            end else if (sweep_shift != 3'd0) begin
              shadow_d = sw_new[FREQ_W-1:0];
              if (sw_ovf2) en_d = 1'b0;
            end
          end
        end else begin
          swt_d = swt_q - 4'd1;
        end
      end

      if (freq_wr) shadow_d = frequency;
    end

    if (HAS_SWEEP == 0) shadow_d = frequency;
    if (!dac_en) en_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      level_q  <= '0;
      div_q    <= '0;
      pos_q    <= 3'd0;
      len_q    <= '0;
      vol_q    <= '0;
      envt_q   <= 3'd0;
      shadow_q <= '0;
      swt_q    <= 4'd0;
      swact_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      level_q  <= level_d;
      div_q    <= div_d;
      pos_q    <= pos_d;
      len_q    <= len_d;
      vol_q    <= vol_d;
      envt_q   <= envt_d;
      shadow_q <= shadow_d;
      swt_q    <= swt_d;
      swact_q  <= swact_d;
    end
  end

  assign level  = level_q;
  assign enable = en_q;

endmodule
